fifo_stream_reader: RTL and testbench

Read-side companion for the team's synchronous FIFO. It drives the FIFO read port (rd_en, empty, registered dout with one-cycle read latency) and re-presents the words as a valid/ready stream to a downstream consumer. A 3-entry skid buffer absorbs the read latency, so the block sustains one word per cycle under continuous m_ready. It also gives full backpressure safety with no combinational path from m_ready to fifo_rd_en. The block shares clk and rst with the FIFO it drains.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/reader_skid_buf.sv | 57 +++++
 rtl/fifo_stream_reader.sv | 64 ++++++
 tb/tb_fifo_stream_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream adapter.
// The skid depth matches the worst-case number of words outstanding.
package fifo_pkg;

   localparam int DEF_DATA_WIDTH  = 8;
   localparam int DEF_COUNT_WIDTH = 16;
   localparam int SKID_DEPTH      = 3;

   typedef logic [1:0] skid_ptr_t;

   localparam skid_ptr_t SKID_LAST = skid_ptr_t'(SKID_DEPTH - 1);
   localparam skid_ptr_t SKID_FULL = skid_ptr_t'(SKID_DEPTH);

   function automatic skid_ptr_t ptr_inc(input skid_ptr_t p);
      return (p == SKID_LAST) ? '0 : p + 2'd1;
   endfunction

endpackage

// File: rtl/reader_skid_buf.sv
// Three-entry circular buffer that absorbs the FIFO read latency.
// Push is the captured read; pop is the downstream handshake.
module reader_skid_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output skid_ptr_t             occ
);

   logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
   skid_ptr_t head;
   skid_ptr_t tail;
   skid_ptr_t occ_q;
   logic      do_pop;

   assign do_pop = pop && (occ_q != '0);
   assign dout   = mem[head];
   assign occ    = occ_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         occ_q <= '0;
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[tail] <= din;
            tail      <= ptr_inc(tail);
         end
         if (do_pop) begin
            head <= ptr_inc(head);
         end
         unique case (1'b1)
            (push && !do_pop): occ_q <= occ_q + 2'd1;
            (!push && do_pop): occ_q <= occ_q - 2'd1;
            default:           occ_q <= occ_q;
         endcase
      end
   end

   // Read issue keeps occ + inflight within depth, so this never fires.
   a_no_overflow: assert property (
      @(posedge clk) disable iff (rst)
      !(push && (occ_q == SKID_FULL))
   );

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO and re-presents it as valid/ready.
// fifo_rd_en depends only on state and FIFO flags, never on m_ready.
module fifo_stream_reader
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   fifo_empty,
   input  logic [DATA_WIDTH-1:0]  fifo_dout,
   output logic                   fifo_rd_en,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] word_count
);

   logic      inflight;
   skid_ptr_t occ;
   logic [2:0] level;
   logic      pop;

   assign level = {1'b0, occ} + {2'b00, inflight};

   assign fifo_rd_en = en && !fifo_empty && !rst
                    && (level < 3'(SKID_DEPTH));

   assign m_valid = (occ != '0);
   assign pop     = m_valid && m_ready;
   assign busy    = inflight || m_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight   <= 1'b0;
         word_count <= '0;
      end else begin
         inflight <= fifo_rd_en;
         if (pop) begin
            word_count <= word_count + COUNT_WIDTH'(1);
         end
      end
   end

   reader_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk  (clk),
      .rst  (rst),
      .push (inflight),
      .pop  (pop),
      .din  (fifo_dout),
      .dout (m_data),
      .occ  (occ)
   );

   a_rd_not_empty: assert property (
      @(posedge clk) fifo_rd_en |-> !fifo_empty
   );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: FIFO model feeds the DUT, monitor checks the stream.
// Expected words are queued at load time and popped on each handshake.
module tb_fifo_stream_reader;

   localparam int DW = 8;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic          fifo_rd_en;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          busy;
   logic [CW-1:0] word_count;

   logic          rd4;
   logic          mv4;
   logic [DW-1:0] md4;
   logic          busy4;
   logic [3:0]    wc4;

   always #5 clk = ~clk;

   fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .en(en),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data),
      .busy(busy), .word_count(word_count)
   );

   fifo_stream_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .en(en),
      .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
      .fifo_rd_en(rd4), .m_valid(mv4),
      .m_ready(m_ready), .m_data(md4),
      .busy(busy4), .word_count(wc4)
   );

   int n_chk  = 0;
   int n_pass = 0;

   logic [DW-1:0] fq[$];
   logic [DW-1:0] exp_q[$];

   bit hold_empty;
   bit rd_lat;
   bit mv_s;
   int rd_cnt;

   logic [CW-1:0] exp_wc;
   int            outstanding;
   bit            stall_v;
   logic [DW-1:0] stall_d;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic refresh_empty();
      fifo_empty = hold_empty || (fq.size() == 0);
   endtask

   task automatic tick();
      refresh_empty();
      #1;
      rd_lat = fifo_rd_en;
      mv_s   = m_valid;
      if (rd_lat) rd_cnt++;
      if (rst) chk("rd_en_in_reset", 32'(rd_lat), 0);
      @(posedge clk);
      #1;
      if (rd_lat) begin
         chk("rd_not_empty", 32'(fq.size() != 0), 1);
         if (fq.size() != 0) fifo_dout = fq.pop_front();
      end
      @(negedge clk);
      refresh_empty();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      fq.delete();
      exp_q.delete();
      rst = 1'b0;
      refresh_empty();
   endtask

   task automatic load(input logic [DW-1:0] w);
      fq.push_back(w);
      exp_q.push_back(w);
   endtask

   task automatic drain(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || fq.size() != 0) && n < limit) begin
         tick();
         n++;
      end
      chk("drain_done", exp_q.size(), 0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            exp_wc      = '0;
            outstanding = 0;
            stall_v     = 1'b0;
         end else begin
            chk("word_count", 32'(word_count), 32'(exp_wc));
            chk("busy", 32'(busy), 32'(outstanding != 0));
            if (stall_v) begin
               chk("stall_valid", 32'(m_valid), 1);
               chk("stall_data", 32'(m_data), 32'(stall_d));
            end
            if (fifo_rd_en) chk("rd_cap", 32'(outstanding < 3), 1);
            if (m_valid && m_ready) begin
               chk("word_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0)
                  chk("m_data", 32'(m_data), 32'(exp_q.pop_front()));
               exp_wc = exp_wc + 16'd1;
            end
            stall_v = m_valid && !m_ready;
            stall_d = m_data;
            outstanding = outstanding + int'(fifo_rd_en)
                        - int'(m_valid && m_ready);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            rd_h [12];
      bit            mv_h [12];
      logic [DW-1:0] first;
      int            pushed;
      int            n;

      rst        = 1'b1;
      en         = 1'b0;
      m_ready    = 1'b0;
      hold_empty = 1'b0;
      fifo_dout  = '0;
      rd_cnt     = 0;
      fifo_empty = 1'b1;
      @(negedge clk);

      // reset with a non-empty FIFO and en high
      en = 1'b1;
      fq.push_back(8'h55);
      do_reset(2);
      en = 1'b0;
      #1;
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_word_count", 32'(word_count), 0);
      chk("rst_m_data", 32'(m_data), 0);

      // streaming latency
      load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
      en      = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         rd_h[i] = rd_lat;
         mv_h[i] = mv_s;
      end
      for (int i = 0; i < 12; i++) begin
         chk("t2_rd_en", 32'(rd_h[i]), 32'(i < 4));
         chk("t2_m_valid", 32'(mv_h[i]), 32'(i >= 2 && i < 6));
      end
      chk("t2_word_count", 32'(word_count), 4);
      chk("t2_busy", 32'(busy), 0);

      // backpressure
      do_reset(1);
      m_ready = 1'b0;
      first   = 8'($urandom);
      load(first);
      for (int i = 1; i < 8; i++) load(8'($urandom));
      rd_cnt = 0;
      repeat (8) tick();
      chk("t3_rd_pulses", rd_cnt, 3);
      chk("t3_fifo_left", fq.size(), 5);
      chk("t3_m_valid", 32'(m_valid), 1);
      chk("t3_m_data", 32'(m_data), 32'(first));
      m_ready = 1'b1;
      drain(200);
      tick();
      chk("t3_word_count", 32'(word_count), 8);
      chk("t3_busy", 32'(busy), 0);

      // random empty and ready
      do_reset(1);
      pushed = 0;
      n      = 0;
      while ((pushed < 200 || exp_q.size() != 0) && n < 5000) begin
         if (pushed < 200 && $urandom_range(0, 3) != 0) begin
            load(8'($urandom));
            pushed++;
         end
         hold_empty = ($urandom_range(0, 2) == 0);
         m_ready    = ($urandom_range(0, 2) != 0);
         tick();
         n++;
      end
      hold_empty = 1'b0;
      m_ready    = 1'b1;
      drain(100);
      tick();
      chk("t4_word_count", 32'(word_count), 200);

      // en drop after third read
      do_reset(1);
      for (int i = 0; i < 6; i++) load(8'(8'h30 + i));
      rd_cnt = 0;
      n      = 0;
      while (rd_cnt < 3 && n < 20) begin
         tick();
         n++;
      end
      en = 1'b0;
      repeat (10) tick();
      chk("t5_rd_pulses", rd_cnt, 3);
      chk("t5_fifo_left", fq.size(), 3);
      chk("t5_undelivered", exp_q.size(), 3);
      en = 1'b1;
      drain(100);
      tick();
      chk("t5_word_count", 32'(word_count), 6);

      // reset with occ=2, inflight=1
      do_reset(1);
      load(8'h11); load(8'h12);
      drain(50);
      tick();
      chk("t6_pre_count", 32'(word_count), 2);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) load(8'(8'h40 + i));
      repeat (3) tick();
      chk("t6_busy_before", 32'(busy), 1);
      chk("t6_valid_before", 32'(m_valid), 1);
      do_reset(1);
      #1;
      chk("t6_m_valid", 32'(m_valid), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_word_count", 32'(word_count), 0);

      // narrow counter wrap
      m_ready = 1'b1;
      for (int i = 0; i < 17; i++) load(8'($urandom));
      drain(100);
      tick();
      chk("t7_word_count", 32'(word_count), 17);
      chk("t7_wc4_wrap", 32'(wc4), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
